// File: rtl/he_pkg.sv
// Shared definitions for the histogram-equalized pixel packer: frame geometry,
// counter widths, FSM encoding and the word record carried through the output FIFO.
package he_pkg;

    localparam int DEF_WIDTH  = 660;
    localparam int DEF_HEIGHT = 440;
    localparam int NUM_PIXELS = DEF_WIDTH * DEF_HEIGHT;
    localparam int NUM_WORDS  = NUM_PIXELS / 4;
    localparam int ADDR_W     = 17;
    localparam int PIX_CNT_W  = 19;
    localparam int ENTRY_W    = 51;

    typedef enum logic [1:0] {
        ST_PACK  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]       data;
        logic [ADDR_W-1:0] addr;
        logic              eol;
        logic              last;
    } word_t;

endpackage

// File: rtl/he_word_fifo.sv
// Synchronous FIFO holding packed output words; full/empty come straight from
// registers so no downstream signal reaches the producer combinationally.
module he_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 51
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL_M1 = (PTR_W+1)'(DEPTH - 1);
    localparam logic [PTR_W:0] CNT_ONE     = (PTR_W+1)'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && !full_r;
    assign pop_ok_s  = pop && !empty_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign full      = full_r;
    assign empty     = empty_r;

    // Storage, pointers and occupancy flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    count_r <= count_r + CNT_ONE;
                    full_r  <= (count_r == CNT_FULL_M1);
                    empty_r <= 1'b0;
                end
                2'b01: begin
                    count_r <= count_r - CNT_ONE;
                    full_r  <= 1'b0;
                    empty_r <= (count_r == CNT_ONE);
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/he_pixel_packer.sv
// Packs a raster stream of 8-bit equalized pixels into little-endian 32-bit
// words tagged with frame word address, end-of-line and end-of-frame flags.
module he_pixel_packer
    import he_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_HEIGHT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_pixel,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_eol,
    output logic              out_last,
    output logic              frame_done
);

    localparam int FRAME_PIX   = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int FRAME_WORDS = FRAME_PIX / 4;
    localparam logic [PIX_CNT_W-1:0] LAST_PIX  = PIX_CNT_W'(FRAME_PIX - 1);
    localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [ADDR_W-1:0]    LAST_COL  = ADDR_W'(IMAGE_WIDTH / 4 - 1);

    state_t               state_r;
    logic                 ready_en_r;
    logic                 frame_done_r;
    logic [23:0]          lane_r;
    logic [1:0]           byte_idx_r;
    logic [PIX_CNT_W-1:0] pix_cnt_r;
    logic [ADDR_W-1:0]    addr_r;
    logic [ADDR_W-1:0]    col_r;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 accept_s;
    logic                 push_s;
    logic                 pop_s;
    word_t                push_word_s;
    word_t                pop_word_s;
    logic [ENTRY_W-1:0]   fifo_rdata_s;

    // ready_en_r keeps in_ready low until the first clock after reset release.
    assign in_ready   = ready_en_r && (state_r == ST_PACK) && !fifo_full_s;
    assign accept_s   = in_valid && in_ready;
    assign push_s     = accept_s && (byte_idx_r == 2'd3);
    assign out_valid  = !fifo_empty_s && (state_r != ST_DONE);
    assign pop_s      = out_valid && out_ready;
    assign pop_word_s = fifo_rdata_s;
    assign out_data   = pop_word_s.data;
    assign out_addr   = pop_word_s.addr;
    assign out_eol    = pop_word_s.eol;
    assign out_last   = pop_word_s.last;
    assign frame_done = frame_done_r;

    // Assemble the word for the FIFO from the three held lanes plus the incoming pixel.
    always_comb begin
        push_word_s      = '0;
        push_word_s.data = {in_pixel, lane_r};
        push_word_s.addr = addr_r;
        push_word_s.eol  = (col_r == LAST_COL);
        push_word_s.last = (addr_r == LAST_ADDR);
    end

    // Byte-lane capture and pixel/word/column counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_r     <= '0;
            byte_idx_r <= 2'd0;
            pix_cnt_r  <= '0;
            addr_r     <= '0;
            col_r      <= '0;
        end else if (accept_s) begin
            case (byte_idx_r)
                2'd0:    lane_r[7:0]   <= in_pixel;
                2'd1:    lane_r[15:8]  <= in_pixel;
                2'd2:    lane_r[23:16] <= in_pixel;
                default: lane_r        <= lane_r;
            endcase
            byte_idx_r <= byte_idx_r + 2'd1;
            pix_cnt_r  <= pix_cnt_r + PIX_CNT_W'(1);
            if (push_s) begin
                addr_r <= addr_r + ADDR_W'(1);
                col_r  <= push_word_s.eol ? '0 : col_r + ADDR_W'(1);
            end
        end
    end

    // Frame sequencing: pack until the last pixel, drain until the last word leaves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_PACK;
            ready_en_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
            case (state_r)
                ST_PACK: begin
                    if (accept_s && (pix_cnt_r == LAST_PIX)) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop_s && pop_word_s.last) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    frame_done_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_PACK;
                end
            endcase
        end
    end

    he_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_word_s),
        .pop       (pop_s),
        .pop_data  (fifo_rdata_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

endmodule

// File: doc/he_pixel_packer.md
HE_PIXEL_PACKER -- requirements
Module: he_pixel_packer

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 660, pixels per line; multiple of 4.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 440, lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output word FIFO entries; power of 2, at least 2.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, in_pixel holds an equalized pixel.
REQ-007 SHALL have port in_pixel, input, 8, equalized pixel value in raster order.
REQ-008 SHALL have port in_ready, output, 1, packer accepts in_pixel this cycle.
REQ-009 SHALL have port out_valid, output, 1, out_data, out_addr, out_eol and out_last are valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the word.
REQ-011 SHALL have port out_data, output, 32, four packed pixels.
REQ-012 SHALL have port out_addr, output, 17, word index within frame, 0..(W*H/4)-1.
REQ-013 SHALL have port out_eol, output, 1, word is last of its line.
REQ-014 SHALL have port out_last, output, 1, word is last of the frame.
REQ-015 SHALL have port frame_done, output, 1, entire frame delivered; sticky until reset.

Function
REQ-016 SHALL implement FSM states PACK, DRAIN and DONE, entering PACK on reset.
REQ-017 Input acceptance SHALL occur when in_valid && in_ready, and in_ready SHALL equal (state==PACK && !fifo_full) with no combinational path from out_ready.
REQ-018 The k-th accepted pixel of each group of four (k=0..3) SHALL be placed in bits [8k+7:8k], little-endian.
REQ-019 The word SHALL be pushed into the FIFO on the same edge that accepts pixel k=3, tagged with word address, eol and last flags.
REQ-020 The word SHALL be visible on out_valid one cycle after that edge when the FIFO was empty; no bypass path is permitted.
REQ-021 Output transfer SHALL occur when out_valid && out_ready, and out_valid SHALL equal !fifo_empty.
REQ-022 out_data/out_addr/out_eol/out_last SHALL hold stable while out_valid && !out_ready.
REQ-023 A push and pop in the same cycle SHALL be allowed at any fill level below full, leaving the count unchanged.
REQ-024 When full, in_ready SHALL be low; a same-cycle pop SHALL NOT re-enable in_ready until the next cycle.
REQ-025 Address counter SHALL increment per pushed word; eol SHALL be set when column word index == IMAGE_WIDTH/4-1; last SHALL be set when address == IMAGE_WIDTH*IMAGE_HEIGHT/4-1.
REQ-026 The pixel counter SHALL be 19 bits; when pixel W*H-1 is accepted, the FSM SHALL go PACK->DRAIN and in_ready SHALL drop on the next cycle.
REQ-027 In DRAIN the FSM SHALL go to DONE on the cycle the out_last word transfers, and frame_done SHALL rise on the following cycle.
REQ-028 In DRAIN and DONE, in_pixel SHALL be ignored and in_ready SHALL be 0; extra pixels are neither counted nor stored.
REQ-029 In DONE out_valid SHALL be 0 and frame_done SHALL be 1 until reset.
REQ-030 Gaps in in_valid SHALL neither advance the byte index nor the counters.

Reset
REQ-031 On reset, in_ready, out_valid and frame_done SHALL be 0 and out_data, out_addr, out_eol and out_last SHALL be 0.
REQ-032 On reset, the FIFO SHALL be emptied, all counters and the byte index zeroed, and state set to PACK; in_ready SHALL rise on the first clock after deassertion.
REQ-033 Reset mid-frame SHALL discard any partial word and all FIFO contents; the next frame SHALL restart at address 0, byte lane 0.

Structure
REQ-034 Package he_pkg SHALL hold the default IMAGE_WIDTH/IMAGE_HEIGHT, NUM_PIXELS, NUM_WORDS, the address width (17) and the FSM state encoding.
REQ-035 Sub-module he_word_fifo SHALL be a synchronous FIFO, 51 bits wide (data 32 + addr 17 + eol + last), with full, empty and registered outputs.
REQ-036 The top level SHALL contain the FSM, byte-lane shift register, counters and handshake logic.

Verification (W=8, H=2 unless stated)
REQ-037 Scenario: pixels 0x00..0x0F streamed back-to-back with out_ready=1 -> words 0x03020100, 0x07060504 (eol=1), 0x0B0A0908, 0x0F0E0D0C (eol=1, last=1) at addr 0..3; frame_done=1 two cycles after the last transfer.
REQ-038 Scenario: out_ready=0 throughout, FIFO_DEPTH=2 -> in_ready drops after the 8th pixel; out_data stays 0x03020100; release resumes with no loss.
REQ-039 Scenario: in_valid toggled 1/0 each cycle -> identical words and addresses as in REQ-037.
REQ-040 Scenario: 20 pixels offered -> only 16 accepted, in_ready=0 after the 16th, exactly 4 words output.
REQ-041 Scenario: reset asserted after 6 pixels, then a fresh 16-pixel frame 0x10..0x1F -> first word 0x13121110 at addr 0, none of the old data appears.
REQ-042 Scenario: defaults 660x440 with random out_ready -> 72600 words, 440 eol pulses, out_last only at addr 72599.
